// File: rtl/if_stage_prefetch_if.sv
// Interface bundling the fetch stage's bus-side signals.
//   freeze                : ID stall
//   br_taken/br_pc/br_offset : redirect request and operands
//   imem_req/imem_addr    : fetch request to instruction memory
//   imem_gnt              : request accepted this cycle
//   imem_rvalid/imem_rdata: in-order fetch response
//   id_valid/id_instr/id_pc : head of the prefetch buffer towards ID
// Modports: master = fetch stage, slave = surrounding memory/ID environment.
interface if_stage_prefetch_if #(
  parameter int WORD_LEN = 32
);
  logic                freeze;
  logic                br_taken;
  logic [WORD_LEN-1:0] br_pc;
  logic [WORD_LEN-1:0] br_offset;
  logic                imem_req;
  logic [WORD_LEN-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [WORD_LEN-1:0] imem_rdata;
  logic                id_valid;
  logic [WORD_LEN-1:0] id_instr;
  logic [WORD_LEN-1:0] id_pc;

  modport master (
    input  freeze, br_taken, br_pc, br_offset, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, id_valid, id_instr, id_pc
  );

  modport slave (
    output freeze, br_taken, br_pc, br_offset, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with sequential prefetch into an in-order FIFO.
// Issues fetches ahead of decode, buffers up to DEPTH {pc, instr} entries and
// presents the head to ID. Redirects flush the buffer and drop in-flight
// responses.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : if_stage_prefetch_if.master (imem request/response, branch, ID)
// Optional (macro IF_PERF_CNT_EN):
//   perf_stall_cycles : cycles with no valid head while not flushing (saturating)
//   perf_redirects    : count of redirects (saturating)
module if_stage_prefetch #(
  parameter int                  WORD_LEN = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  if_stage_prefetch_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_redirects
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]          r_state;
  logic [WORD_LEN-1:0] r_fetch_pc;
  logic [WORD_LEN-1:0] r_resp_pc;
  logic [CW-1:0]       r_out_cnt;
  logic [CW-1:0]       r_drop;
  logic [CW-1:0]       r_count;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [WORD_LEN-1:0] r_pc_mem  [DEPTH];
  logic [WORD_LEN-1:0] r_ins_mem [DEPTH];

  logic [WORD_LEN-1:0] w_target;
  logic                w_room;
  logic                w_req;
  logic                w_grant;
  logic                w_accept;
  logic                w_pop;
  logic [CW-1:0]       w_drop_base;
  logic [CW-1:0]       w_drop_next;
  logic                w_valid;

  assign w_target = bus.br_pc + WORD_LEN'(4) + (bus.br_offset << 2);

  // Buffered plus outstanding fetches never exceed DEPTH, so the FIFO cannot overflow.
  assign w_room   = ({1'b0, r_count} + {1'b0, r_out_cnt}) < (CW + 1)'(DEPTH);
  assign w_req    = !rst && (r_state == ST_FETCH) && w_room;
  assign w_grant  = w_req && bus.imem_gnt;
  assign w_accept = (r_state == ST_FETCH) && bus.imem_rvalid && !bus.br_taken;
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid && !bus.freeze && !bus.br_taken;

  // One expression serves both the redirect and the flush countdown: in FLUSH
  // no request is issued, so the grant term is zero there.
  assign w_drop_base = (r_state == ST_FLUSH) ? r_drop : r_out_cnt;
  assign w_drop_next = w_drop_base + CW'(w_grant) - CW'(bus.imem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (bus.br_taken) begin
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
      r_out_cnt  <= '0;
      r_drop     <= w_drop_next;
      r_state    <= (w_drop_next == '0) ? ST_FETCH : ST_FLUSH;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + WORD_LEN'(4);
      if (r_state == ST_FLUSH) begin
        r_drop <= w_drop_next;
        if (w_drop_next == '0) r_state <= ST_FETCH;
      end else begin
        r_out_cnt <= r_out_cnt + CW'(w_grant) - CW'(w_accept);
      end
      if (w_accept) begin
        r_wptr    <= r_wptr + AW'(1);
        r_resp_pc <= r_resp_pc + WORD_LEN'(4);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_accept) - CW'(w_pop);
    end
  end

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc_mem[r_wptr]  <= r_resp_pc;
      r_ins_mem[r_wptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.id_valid  = w_valid;
  assign bus.id_instr  = w_valid ? r_ins_mem[r_rptr] : '0;
  assign bus.id_pc     = w_valid ? r_pc_mem[r_rptr]  : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (!w_valid && (r_state != ST_FLUSH) && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (bus.br_taken && (r_perf_redir != '1))
        r_perf_redir <= r_perf_redir + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_redirects    = r_perf_redir;
`endif

endmodule
